// File: rtl/sm_ram_wait.sv
// sm_ram_wait: word-addressed data RAM behind a valid/ready handshake with WAIT wait states per access.
// Optional build macro SM_RAM_WAIT_LFSR_EN makes the per-request wait pseudo-random in 0..WAIT.
module sm_ram_wait #(
    parameter int SIZE = 64,
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] rd
);
    localparam int AW = $clog2(SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [7:0]    w_cnt_load;
    logic [AW-1:0] r_idx;
    logic          r_we;
    logic [31:0]   r_wd;
    logic          r_ready;
    logic          w_ready_nxt;
    logic [31:0]   r_rd;
    logic          w_accept;
    logic          w_access;
    logic [31:0]   r_mem [SIZE];

    // Address bits outside the word index are deliberately ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{a[31:AW+2], a[1:0]};

`ifdef SM_RAM_WAIT_LFSR_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_cnt_load = 8'(32'(r_lfsr) % 32'(WAIT + 1));

    // LFSR steps once per accepted request; the pre-advance value sets the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 8'h01;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_nxt;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end
`else
    assign w_cnt_load = 8'(WAIT);
`endif

    // Next-state and wait-counter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = w_cnt_load;
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_access    = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and registered ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Request fields are frozen at accept so the master may change them while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_we  <= 1'b0;
            r_wd  <= 32'd0;
        end else if (w_accept) begin
            r_idx <= a[AW+1:2];
            r_we  <= we;
            r_wd  <= wd;
        end else begin
            r_idx <= r_idx;
            r_we  <= r_we;
            r_wd  <= r_wd;
        end
    end

    // Read data only moves on a read access, so it survives writes and idle time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= 32'd0;
        end else if (w_access && !r_we) begin
            r_rd <= r_mem[r_idx];
        end else begin
            r_rd <= r_rd;
        end
    end

    // Storage is never cleared; an aborted request never reaches the access state.
    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            r_mem[r_idx] <= r_wd;
        end
    end

    assign ready = r_ready;
    assign rd    = r_rd;

endmodule

// File: tb/tb_sm_ram_wait.sv
// Directed self-checking bench for sm_ram_wait: four instances with WAIT = 2, 0, 3 and 7.
module tb_sm_ram_wait;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [31:0] rd [4];
    logic [7:0]  m_lfsr [4];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    sm_ram_wait #(.SIZE(64), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd),
        .valid(valid[0]), .ready(ready[0]), .rd(rd[0]));
    sm_ram_wait #(.SIZE(64), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd),
        .valid(valid[1]), .ready(ready[1]), .rd(rd[1]));
    sm_ram_wait #(.SIZE(64), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd),
        .valid(valid[2]), .ready(ready[2]), .rd(rd[2]));
    sm_ram_wait #(.SIZE(64), .WAIT(7)) u_w7 (
        .clk(clk), .rst(rst), .a(a), .we(we), .wd(wd),
        .valid(valid[3]), .ready(ready[3]), .rd(rd[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nominal_wait(input int sel);
        case (sel)
            0:       return 2;
            1:       return 0;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    task automatic model_accept(input int sel, output int w);
`ifdef SM_RAM_WAIT_LFSR_EN
        w = int'(m_lfsr[sel]) % (nominal_wait(sel) + 1);
        m_lfsr[sel] = {m_lfsr[sel][6:0], m_lfsr[sel][7] ^ m_lfsr[sel][5] ^ m_lfsr[sel][4] ^ m_lfsr[sel][3]};
`else
        w = nominal_wait(sel);
`endif
    endtask

    // One request on instance sel; latency is counted in cycles after the accept cycle.
    task automatic req(input string tag, input int sel, input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input bit hold, input bit disturb,
                       output int lat, output logic [31:0] rdata);
        int w;
        @(negedge clk);
        a = addr; we = wr; wd = data; valid[sel] = 1'b1;
        model_accept(sel, w);
        @(posedge clk); #1;
        if (disturb) begin
            valid[sel] = 1'b0; a = ~addr; we = ~wr; wd = ~data;
        end
        lat = 1;
        while (ready[sel] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rd[sel];
        check({tag, ".latency"}, 32'(lat), 32'(w + 2));
        if (!hold) valid[sel] = 1'b0;
        @(posedge clk); #1;
        check({tag, ".single_pulse"}, {31'd0, ready[sel]}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          w;
        logic [31:0] rdata;
        logic [3:0]  seen;
        int          lfsr_lat [8];

        rst = 1'b1; a = 32'd0; we = 1'b0; wd = 32'd0; valid = 4'd0;
        for (int i = 0; i < 4; i++) m_lfsr[i] = 8'h01;
`ifdef SM_RAM_WAIT_LFSR_EN
        lfsr_lat = '{3, 4, 6, 2, 3, 5, 9, 8};
`else
        lfsr_lat = '{9, 9, 9, 9, 9, 9, 9, 9};
`endif

        // 1. reset state and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check("reset.ready", {28'd0, ready}, 32'd0);
        for (int i = 0; i < 4; i++) check("reset.rd", rd[i], 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            seen = seen | ready;
        end
        check("idle.no_ready", {28'd0, seen}, 32'd0);
        check("idle.rd", rd[0], 32'd0);

        // 2. WAIT=2 write then read
        req("w2.write", 0, 32'h8, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, lat, rdata);
        check("w2.write_rd_hold", rdata, 32'd0);
        req("w2.read", 0, 32'h8, 1'b0, 32'd0, 1'b0, 1'b0, lat, rdata);
        check("w2.read_data", rdata, 32'hDEADBEEF);

        // 3. WAIT=0 aliasing and ignored byte offset
        req("w0.write", 1, 32'h100, 1'b1, 32'h12345678, 1'b0, 1'b0, lat, rdata);
        req("w0.read0", 1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, lat, rdata);
        check("w0.alias_data", rdata, 32'h12345678);
        req("w0.read3", 1, 32'h3, 1'b0, 32'd0, 1'b0, 1'b0, lat, rdata);
        check("w0.byteoff_data", rdata, 32'h12345678);

        // 4. WAIT=2 inputs disturbed while busy
        req("w2.write4", 0, 32'h4, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, lat, rdata);
        req("w2.disturb", 0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1, lat, rdata);
        check("w2.disturb_data", rdata, 32'hCAFEF00D);
        req("w2.reread4", 0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, lat, rdata);
        check("w2.mem_unchanged", rdata, 32'hCAFEF00D);
        req("w2.reread8", 0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, lat, rdata);
        check("w2.other_unchanged", rdata, 32'hDEADBEEF);

        // 5. WAIT=3 write aborted by reset in the second busy cycle
        req("w3.prime", 2, 32'hC, 1'b1, 32'h11112222, 1'b0, 1'b0, lat, rdata);
        @(negedge clk);
        a = 32'hC; we = 1'b1; wd = 32'hAAAA5555; valid[2] = 1'b1;
        model_accept(2, w);
        @(posedge clk); #1;
        valid[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) m_lfsr[i] = 8'h01;
        #1;
        check("abort.ready_in_reset", {28'd0, ready}, 32'd0);
        check("abort.rd_cleared", rd[0], 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | ready;
        end
        check("abort.no_ready", {28'd0, seen}, 32'd0);
        req("w3.readback", 2, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, lat, rdata);
        check("abort.prior_data", rdata, 32'h11112222);

        // 6. WAIT=7 back-to-back reads with valid held high
        for (int i = 0; i < 8; i++) begin
            req("w7.b2b", 3, 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b0, lat, rdata);
            check("w7.b2b_table", 32'(lat), 32'(lfsr_lat[i]));
        end
        valid[3] = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
